// File: rtl/lab2_proc_intmuldivunitvrtl.sv
// Iterative integer multiply/divide unit: shift-add MUL and restoring DIV/REM,
// one bit per cycle, with a val/rdy request stream and a val/rdy result stream.
module lab2_proc_intmuldivunitvrtl #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_fn,
  input  logic [p_nbits-1:0] istream_op0,
  input  logic [p_nbits-1:0] istream_op1,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_result
);

  localparam int unsigned W  = p_nbits;
  localparam int unsigned CW = $clog2(p_nbits + 1);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      fn_q;
  logic [W-1:0]    a_q;       // multiplicand, or dividend shifting out / quotient shifting in
  logic [W-1:0]    b_q;       // multiplier, or divisor magnitude
  logic [W-1:0]    acc_q;     // product, or partial remainder
  logic [W-1:0]    a_orig_q;  // original dividend for divide-by-zero remainder
  logic            qneg_q;
  logic            rneg_q;
  logic            bzero_q;
  logic            rdy_q;
  logic            val_q;
  logic [W-1:0]    result_q;

  logic            is_mul_c;
  logic [W:0]      div_rem_c;
  logic            div_ge_c;
  logic [W-1:0]    a_d;
  logic [W-1:0]    b_d;
  logic [W-1:0]    acc_d;
  logic [W-1:0]    result_d;
  logic            sgn_c;
  logic [W-1:0]    op0_mag_c;
  logic [W-1:0]    op1_mag_c;

  // One iteration of the shift-add multiply or restoring divide, plus final result select
  always_comb begin
    is_mul_c  = (fn_q == FN_MUL);
    div_rem_c = {acc_q, a_q[W-1]};
    div_ge_c  = (div_rem_c >= {1'b0, b_q});
    if (is_mul_c) begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
    end else begin
      acc_d = div_ge_c ? (div_rem_c[W-1:0] - b_q) : div_rem_c[W-1:0];
      a_d   = {a_q[W-2:0], div_ge_c};
      b_d   = b_q;
    end
    result_d = '0;
    case (fn_q)
      FN_MUL:  result_d = acc_d;
      FN_DIV:  result_d = bzero_q ? '1 : (qneg_q ? W'(-a_d) : a_d);
      FN_DIVU: result_d = bzero_q ? '1 : a_d;
      FN_REM:  result_d = bzero_q ? a_orig_q : (rneg_q ? W'(-acc_d) : acc_d);
      FN_REMU: result_d = bzero_q ? a_orig_q : acc_d;
      default: result_d = '0;
    endcase
  end

  // Operand magnitudes for signed divide/remainder
  always_comb begin
    sgn_c     = (istream_fn == FN_DIV) || (istream_fn == FN_REM);
    op0_mag_c = (sgn_c && istream_op0[W-1]) ? W'(-istream_op0) : istream_op0;
    op1_mag_c = (sgn_c && istream_op1[W-1]) ? W'(-istream_op1) : istream_op1;
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fn_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      a_orig_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      rdy_q    <= 1'b1;
      val_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (istream_val) begin
            state_q  <= CALC;
            cnt_q    <= CW'(p_nbits);
            fn_q     <= istream_fn;
            acc_q    <= '0;
            a_orig_q <= istream_op0;
            bzero_q  <= (istream_op1 == '0);
            qneg_q   <= sgn_c && (istream_op0[W-1] ^ istream_op1[W-1]);
            rneg_q   <= sgn_c && istream_op0[W-1];
            rdy_q    <= 1'b0;
            if (istream_fn == FN_MUL) begin
              a_q <= istream_op0;
              b_q <= istream_op1;
            end else begin
              a_q <= op0_mag_c;
              b_q <= op1_mag_c;
            end
          end
        end
        CALC: begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q  <= DONE;
            val_q    <= 1'b1;
            result_q <= result_d;
          end
        end
        DONE: begin
          if (ostream_rdy) begin
            state_q <= IDLE;
            val_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          val_q   <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign istream_rdy    = rdy_q;
  assign ostream_val    = val_q;
  assign ostream_result = result_q;

endmodule

// File: tb/tb_lab2_proc_intmuldivunitvrtl.sv
// Directed bench for the iterative multiply/divide unit.
module tb_lab2_proc_intmuldivunitvrtl;

  logic        clk;
  logic        reset;
  logic        istream_val;
  logic        istream_rdy;
  logic [2:0]  istream_fn;
  logic [31:0] istream_op0;
  logic [31:0] istream_op1;
  logic        ostream_val;
  logic        ostream_rdy;
  logic [31:0] ostream_result;

  int vectors = 0;
  int miscompares = 0;

  lab2_proc_intmuldivunitvrtl #(.p_nbits(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .istream_val    (istream_val),
    .istream_rdy    (istream_rdy),
    .istream_fn     (istream_fn),
    .istream_op0    (istream_op0),
    .istream_op1    (istream_op1),
    .ostream_val    (ostream_val),
    .ostream_rdy    (ostream_rdy),
    .ostream_result (ostream_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for istream_rdy at a negedge, then present one request for one edge
  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int n;
    n = 0;
    while (!istream_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " rdy_before_issue"}, 32'(istream_rdy), 32'd1);
    istream_val = 1'b1;
    istream_fn  = fn;
    istream_op0 = a;
    istream_op1 = b;
    @(negedge clk);
    istream_val = 1'b0;
  endtask

  // Count cycles after acceptance until ostream_val rises (bounded)
  task automatic wait_result(input string tag, output int lat);
    lat = 1;
    while (!ostream_val && lat < 45) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd33);
  endtask

  // Full operation with ostream_rdy high: latency, result, return to idle
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int lat;
    issue(fn, a, b, tag);
    wait_result(tag, lat);
    check({tag, " result"}, ostream_result, exp);
    @(negedge clk);
    check({tag, " rdy_after"}, 32'(istream_rdy), 32'd1);
    check({tag, " val_after"}, 32'(ostream_val), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    reset       = 1'b1;
    istream_val = 1'b0;
    istream_fn  = 3'd0;
    istream_op0 = 32'd0;
    istream_op1 = 32'd0;
    ostream_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_rdy", 32'(istream_rdy), 32'd1);
      check("idle_val", 32'(ostream_val), 32'd0);
      check("idle_result", ostream_result, 32'd0);
    end

    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    run_op(3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, "mul_ffff_sq");
    run_op(3'd1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2");
    run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2");
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, "divu_big_2");
    run_op(3'd1, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "div_100_m7");
    run_op(3'd3, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, "rem_100_m7");
    run_op(3'd4, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, "remu_100_7");
    run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
    run_op(3'd1, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "div_5_0");
    run_op(3'd3, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, "rem_m5_0");
    run_op(3'd2, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, "divu_7_0");
    run_op(3'd4, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, "remu_x_0");
    run_op(3'd5, 32'h0000_0064, 32'h0000_0003, 32'h0000_0000, "reserved_fn");

    // Backpressure in DONE with a new request held valid
    ostream_rdy = 1'b0;
    issue(3'd2, 32'd100, 32'd3, "bp");
    wait_result("bp", lat);
    istream_val = 1'b1;
    istream_fn  = 3'd0;
    istream_op0 = 32'd9;
    istream_op1 = 32'd9;
    held = 32'd33;
    for (int i = 0; i < 10; i++) begin
      check("bp_result", ostream_result, held);
      check("bp_val", 32'(ostream_val), 32'd1);
      check("bp_rdy", 32'(istream_rdy), 32'd0);
      @(negedge clk);
    end
    check("bp_result_end", ostream_result, held);
    ostream_rdy = 1'b1;
    @(negedge clk);
    istream_val = 1'b0;
    check("bp_val_after", 32'(ostream_val), 32'd0);
    check("bp_rdy_after", 32'(istream_rdy), 32'd1);
    @(negedge clk);
    check("bp_no_new_req", 32'(istream_rdy), 32'd1);

    // Reset in the middle of CALC, then a fresh MUL
    issue(3'd1, 32'd100, 32'd3, "rst_mid");
    for (int i = 1; i < 15; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_rdy", 32'(istream_rdy), 32'd1);
    check("rst_mid_val", 32'(ostream_val), 32'd0);
    check("rst_mid_result", ostream_result, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (ostream_val) seen = 1;
      end
      check("rst_mid_never_val", 32'(seen), 32'd0);
    end
    run_op(3'd0, 32'd6, 32'd7, 32'd42, "mul_6_7_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
